// File: rtl/gd_frame_sync_if.sv
// Game-data write channel between the game logic (master) and the frame
// sync controller (slave).
//
// Handshake: a word moves when wr_valid && wr_ready are both high at a rising
// clock edge. The master holds wr_data and wr_last stable while wr_valid is
// high and the word has not yet moved. wr_ready may drop at any time without
// regard to wr_valid. wr_last marks the final word of one frame.
interface gd_frame_sync_if #(
  parameter int WORD_W = 24
);
  logic              wr_valid;
  logic [WORD_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/gd_frame_sync.sv
// Frame-synchronous ping-pong buffer for game data.
//
// The game logic fills a back buffer one word at a time. The filled frame is
// copied to the front buffer only on the first clock of vertical blanking.
// Because of this, the draw pipeline never shows a half-updated frame.
module gd_frame_sync #(
  parameter int WORDS     = 32,
  parameter int WORD_W    = 24,
  parameter int PIX_WIDTH = 12,
  parameter int V_DISP    = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    pix_de_i,
  input  logic [PIX_WIDTH-1:0]    pix_y_i,
  input  logic                    wr_valid_i,
  input  logic [WORD_W-1:0]       wr_data_i,
  input  logic                    wr_last_i,
  output logic                    wr_ready_o,
  output logic [WORDS*WORD_W-1:0] front_data_o,
  output logic                    swap_o,
  output logic                    late_o,
  output logic                    err_len_o,
  output logic [15:0]             frame_cnt_o
);

  localparam int                   PTR_W     = $clog2(WORDS);
  localparam int                   FW        = WORDS * WORD_W;
  localparam logic [PTR_W-1:0]     LAST_PTR  = PTR_W'(WORDS - 1);
  localparam logic [PIX_WIDTH-1:0] LAST_LINE = PIX_WIDTH'(V_DISP - 1);

  // FILL: accepting words. PENDING: frame complete, waiting for vblank.
  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [FW-1:0]    back_q, back_d;
  logic [FW-1:0]    front_q, front_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             swap_q, swap_d;
  logic             late_q, late_d;
  logic             err_q, err_d;
  logic             de_q;

  logic vblank_start;
  logic xfer;
  logic at_end;
  logic terminal;

  // Vblank begins on the falling edge of DE after the last visible line.
  assign vblank_start = de_q && !pix_de_i && (pix_y_i == LAST_LINE);
  assign xfer         = wr_valid_i && ready_q && (state_q == ST_FILL);
  assign at_end       = (wptr_q == LAST_PTR);
  assign terminal     = wr_last_i || at_end;

  // Next-state logic: fill the back buffer, then publish it at vblank.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    back_d  = back_q;
    front_d = front_q;
    cnt_d   = cnt_q;
    swap_d  = 1'b0;
    late_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (xfer) begin
          back_d[int'(wptr_q)*WORD_W +: WORD_W] = wr_data_i;
          if (terminal) begin
            // wptr holds here until the swap resets it to zero.
            state_d = ST_PENDING;
            err_d   = wr_last_i ^ at_end;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end
        // A partial frame missed this vblank. A word that completes the frame
        // in the vblank cycle itself does not count as late.
        if (vblank_start && (wptr_q != '0) && !(xfer && terminal)) begin
          late_d = 1'b1;
        end
      end
      ST_PENDING: begin
        if (vblank_start) begin
          front_d = back_q;
          swap_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          wptr_d  = '0;
          state_d = ST_FILL;
        end
      end
    endcase
    ready_d = (state_d == ST_FILL);
  end

  // State and datapath registers. All of them clear at once on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_FILL;
      wptr_q  <= '0;
      back_q  <= '0;
      front_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      swap_q  <= 1'b0;
      late_q  <= 1'b0;
      err_q   <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      back_q  <= back_d;
      front_q <= front_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      swap_q  <= swap_d;
      late_q  <= late_d;
      err_q   <= err_d;
      de_q    <= pix_de_i;
    end
  end

  assign wr_ready_o   = ready_q;
  assign front_data_o = front_q;
  assign swap_o       = swap_q;
  assign late_o       = late_q;
  assign err_len_o    = err_q;
  assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_gd_frame_sync.sv
// Testbench for gd_frame_sync: directed scenarios plus a randomized run
// checked against a frame-level reference model.
module tb_gd_frame_sync;

  localparam int TW = 4;
  localparam int TB = 8;
  localparam int TP = 12;
  localparam int TV = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          pix_de = 1'b0;
  logic [TP-1:0] pix_y  = '0;
  logic [TW*TB-1:0] front;
  logic             swap, late, err_len;
  logic [15:0]      frame_cnt;

  gd_frame_sync_if #(.WORD_W(TB)) wif ();

  gd_frame_sync #(.WORDS(TW), .WORD_W(TB), .PIX_WIDTH(TP), .V_DISP(TV)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .pix_de_i     (pix_de),
    .pix_y_i      (pix_y),
    .wr_valid_i   (wif.wr_valid),
    .wr_data_i    (wif.wr_data),
    .wr_last_i    (wif.wr_last),
    .wr_ready_o   (wif.wr_ready),
    .front_data_o (front),
    .swap_o       (swap),
    .late_o       (late),
    .err_len_o    (err_len),
    .frame_cnt_o  (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // reference model: frame-level view of the buffers
  logic [TB-1:0] m_back [TW];
  logic [TB-1:0] m_front[TW];
  int            m_wptr;
  bit            m_pending, m_ready, m_de_d;
  logic          m_swap, m_late, m_err;
  logic [15:0]   m_cnt;

  task automatic model_reset();
    for (int i = 0; i < TW; i++) begin
      m_back[i]  = '0;
      m_front[i] = '0;
    end
    m_wptr = 0; m_pending = 0; m_ready = 0; m_de_d = 0;
    m_swap = 0; m_late = 0; m_err = 0; m_cnt = '0;
  endtask

  task automatic model_step();
    bit vb, xfer, at_end, term;
    vb   = m_de_d && !pix_de && (int'(pix_y) == TV - 1);
    xfer = wif.wr_valid && m_ready;
    m_swap = 0; m_late = 0; m_err = 0;
    if (!m_pending) begin
      at_end = (m_wptr == TW - 1);
      term   = xfer && (wif.wr_last || at_end);
      if (vb && m_wptr != 0 && !term) m_late = 1;
      if (xfer) begin
        m_back[m_wptr] = wif.wr_data;
        if (term) begin
          m_pending = 1;
          m_err     = (wif.wr_last != at_end);
        end else begin
          m_wptr++;
        end
      end
    end else if (vb) begin
      for (int i = 0; i < TW; i++) m_front[i] = m_back[i];
      m_swap = 1;
      m_cnt  = m_cnt + 16'd1;
      m_wptr = 0;
      m_pending = 0;
    end
    m_ready = !m_pending;
    m_de_d  = pix_de;
  endtask

  function automatic logic [TW*TB-1:0] exp_front();
    logic [TW*TB-1:0] r;
    for (int k = 0; k < TW; k++) r[k*TB +: TB] = m_front[k];
    return r;
  endfunction

  // driver tasks
  task automatic set_in(input logic v, input logic [TB-1:0] d, input logic l,
                        input logic de, input logic [TP-1:0] y);
    wif.wr_valid = v;
    wif.wr_data  = d;
    wif.wr_last  = l;
    pix_de       = de;
    pix_y        = y;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write_word(input logic [TB-1:0] d, input logic l);
    set_in(1'b1, d, l, 1'b1, '0);
    cyc();
    set_in(1'b0, '0, 1'b0, 1'b1, '0);
  endtask

  // One visible cycle, then the DE fall on the last line.
  task automatic vblank();
    set_in(1'b0, '0, 1'b0, 1'b1, '0);
    cyc();
    set_in(1'b0, '0, 1'b0, 1'b0, TP'(TV - 1));
    cyc();
    set_in(1'b0, '0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_reset();
    set_in(1'b0, '0, 1'b0, 1'b1, '0);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wif.wr_ready, swap, late, err_len, frame_cnt, front} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b swp=%0b late=%0b err=%0b cnt=%h front=%h, want all 0",
               wif.wr_ready, swap, late, err_len, frame_cnt, front);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc();
    checks++;
    if (wif.wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %0b want 1", wif.wr_ready);
    end
  endtask

  task automatic test_basic();
    write_word(8'h11, 1'b0);
    write_word(8'h22, 1'b0);
    write_word(8'h33, 1'b0);
    checks++;
    if (wif.wr_ready !== 1'b1) begin
      errors++; $display("FAIL basic_ready_fill: got %0b want 1", wif.wr_ready);
    end
    write_word(8'h44, 1'b1);
    checks++;
    if ({wif.wr_ready, err_len} !== 2'b00) begin
      errors++; $display("FAIL basic_after_last: got rdy=%0b err=%0b want 0 0", wif.wr_ready, err_len);
    end
    // Valid words while pending must be ignored.
    repeat (2) begin
      set_in(1'b1, 8'hEE, 1'b0, 1'b1, '0);
      cyc();
      checks++;
      if ({wif.wr_ready, swap} !== 2'b00) begin
        errors++; $display("FAIL basic_pending: got rdy=%0b swp=%0b want 0 0", wif.wr_ready, swap);
      end
    end
    vblank();
    checks++;
    if ({front, swap, frame_cnt, wif.wr_ready} !== {32'h44332211, 1'b1, 16'd1, 1'b1}) begin
      errors++;
      $display("FAIL basic_swap: got front=%h swp=%0b cnt=%0d rdy=%0b want 44332211 1 1 1",
               front, swap, frame_cnt, wif.wr_ready);
    end
    cyc();
    checks++;
    if ({swap, front} !== {1'b0, 32'h44332211}) begin
      errors++; $display("FAIL basic_swap_pulse: got swp=%0b front=%h want 0 44332211", swap, front);
    end
  endtask

  task automatic test_short_frame();
    write_word(8'h55, 1'b0);
    write_word(8'h66, 1'b1);
    checks++;
    if (err_len !== 1'b1) begin
      errors++; $display("FAIL short_err_pulse: got %0b want 1", err_len);
    end
    cyc();
    checks++;
    if (err_len !== 1'b0) begin
      errors++; $display("FAIL short_err_clear: got %0b want 0", err_len);
    end
    vblank();
    checks++;
    if ({front, frame_cnt} !== {32'h44336655, 16'd2}) begin
      errors++; $display("FAIL short_front: got %h cnt=%0d want 44336655 cnt=2", front, frame_cnt);
    end
  endtask

  task automatic test_late();
    logic [15:0] cnt_before;
    cnt_before = frame_cnt;
    write_word(8'hA1, 1'b0);
    write_word(8'hA2, 1'b0);
    vblank();
    checks++;
    if ({late, swap, front} !== {1'b1, 1'b0, 32'h44336655}) begin
      errors++; $display("FAIL late_pulse: got late=%0b swp=%0b front=%h want 1 0 44336655", late, swap, front);
    end
    cyc();
    checks++;
    if (late !== 1'b0) begin
      errors++; $display("FAIL late_clear: got %0b want 0", late);
    end
    write_word(8'hA3, 1'b0);
    write_word(8'hA4, 1'b1);
    checks++;
    if (err_len !== 1'b0) begin
      errors++; $display("FAIL late_len_ok: got err=%0b want 0", err_len);
    end
    vblank();
    checks++;
    if ({swap, front, frame_cnt} !== {1'b1, 32'hA4A3A2A1, cnt_before + 16'd1}) begin
      errors++;
      $display("FAIL late_swap: got swp=%0b front=%h cnt=%0d want 1 A4A3A2A1 %0d",
               swap, front, frame_cnt, cnt_before + 16'd1);
    end
  endtask

  task automatic test_term_at_vblank();
    write_word(8'hB1, 1'b0);
    write_word(8'hB2, 1'b0);
    write_word(8'hB3, 1'b0);
    set_in(1'b1, 8'hB4, 1'b1, 1'b0, TP'(TV - 1));
    cyc();
    checks++;
    if ({swap, late, wif.wr_ready} !== 3'b000) begin
      errors++; $display("FAIL term_vblank: got swp=%0b late=%0b rdy=%0b want 0 0 0", swap, late, wif.wr_ready);
    end
    set_in(1'b0, '0, 1'b0, 1'b1, '0);
    cyc();
    vblank();
    checks++;
    if ({swap, late, front} !== {1'b1, 1'b0, 32'hB4B3B2B1}) begin
      errors++; $display("FAIL term_next_swap: got swp=%0b late=%0b front=%h want 1 0 B4B3B2B1", swap, late, front);
    end
  endtask

  task automatic test_reset_mid_pending();
    write_word(8'hC1, 1'b0);
    write_word(8'hC2, 1'b0);
    write_word(8'hC3, 1'b0);
    write_word(8'hC4, 1'b1);
    cyc();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({wif.wr_ready, swap, late, err_len, frame_cnt, front} !== '0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%0b swp=%0b late=%0b err=%0b cnt=%h front=%h, want all 0",
               wif.wr_ready, swap, late, err_len, frame_cnt, front);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc();
    checks++;
    if ({wif.wr_ready, front, frame_cnt} !== {1'b1, 32'h0, 16'h0}) begin
      errors++; $display("FAIL async_release: got rdy=%0b front=%h cnt=%h want 1 0 0", wif.wr_ready, front, frame_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    write_word(8'hD1, 1'b1);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFF;
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %h want FFFF", frame_cnt);
    end
    vblank();
    checks++;
    if ({swap, frame_cnt, front} !== {1'b1, 16'h0000, 32'h000000D1}) begin
      errors++; $display("FAIL wrap_swap: got swp=%0b cnt=%h front=%h want 1 0000 000000D1", swap, frame_cnt, front);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      set_in(1'($urandom_range(0, 1)), TB'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) != 0), TP'($urandom_range(2, 3)));
      cyc();
      checks++;
      if ({wif.wr_ready, swap, late, err_len} !== {m_ready, m_swap, m_late, m_err}) begin
        errors++;
        $display("FAIL rand_flags cyc %0d: got rdy/swp/late/err=%b want %b", n,
                 {wif.wr_ready, swap, late, err_len}, {m_ready, m_swap, m_late, m_err});
      end
      checks++;
      if (front !== exp_front()) begin
        errors++; $display("FAIL rand_front cyc %0d: got %h want %h", n, front, exp_front());
      end
      checks++;
      if (frame_cnt !== m_cnt) begin
        errors++; $display("FAIL rand_cnt cyc %0d: got %0d want %0d", n, frame_cnt, m_cnt);
      end
    end
    set_in(1'b0, '0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_short_frame();
    test_late();
    test_term_at_vblank();
    test_reset_mid_pending();
    test_cnt_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
